// File: rtl/chaser_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : chaser_sequencer
// Description : Command-driven LED chaser. Each accepted command runs one of
//               the modes ROTL, ROTR, BOUNCE or BLINK for a programmed number
//               of steps, one step every TICKS_PER_STEP unpaused clocks.
//               Optional macro CHASER_ABORT_EN adds the abort/aborted ports.
// Revision    : 1.0 - initial release
// ============================================================================
module chaser_sequencer #(
    parameter int WIDTH          = 8,
    parameter int TICKS_PER_STEP = 4,
    parameter int STEPS_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               pause,
`ifdef CHASER_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic [WIDTH-1:0]   led_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         cur_mode
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_MODE_ROTL   = 2'd0;
    localparam logic [1:0] c_MODE_ROTR   = 2'd1;
    localparam logic [1:0] c_MODE_BOUNCE = 2'd2;
    localparam logic [1:0] c_MODE_BLINK  = 2'd3;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    localparam int                  c_TICK_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [STEPS_W-1:0]  c_STEP_ONE  = STEPS_W'(1);
    localparam logic [WIDTH-1:0]    c_LED_INIT  = WIDTH'(1);

    logic [1:0]          r_state;
    logic [1:0]          r_mode;
    logic [STEPS_W-1:0]  r_steps;
    logic [STEPS_W-1:0]  r_step_cnt;
    logic [c_TICK_W-1:0] r_tick;
    logic                r_dir;
    logic [WIDTH-1:0]    r_led;

    logic [WIDTH-1:0]    w_led_step;
    logic                w_dir_step;
    logic                w_onehot;
    logic                w_tick_wrap;
    logic                w_last_step;

    assign w_onehot    = (r_led != '0) && ((r_led & (r_led - c_LED_INIT)) == '0);
    assign w_tick_wrap = (r_tick == c_TICK_LAST);
    assign w_last_step = (r_step_cnt == (r_steps - c_STEP_ONE));

    // Next pattern and bounce direction if a step happens this edge.
    always_comb begin
        w_led_step = r_led;
        w_dir_step = r_dir;
        case (r_mode)
            c_MODE_ROTL: w_led_step = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            c_MODE_ROTR: w_led_step = {r_led[0], r_led[WIDTH-1:1]};
            c_MODE_BOUNCE: begin
                if (r_dir == c_DIR_LEFT) begin
                    if (r_led[WIDTH-1]) begin
                        w_led_step = r_led >> 1;
                        w_dir_step = c_DIR_RIGHT;
                    end else begin
                        w_led_step = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_led_step = r_led << 1;
                        w_dir_step = c_DIR_LEFT;
                    end else begin
                        w_led_step = r_led >> 1;
                    end
                end
            end
            c_MODE_BLINK: w_led_step = ~r_led;
            default:      w_led_step = r_led;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_mode     <= 2'd0;
            r_steps    <= '0;
            r_step_cnt <= '0;
            r_tick     <= '0;
            r_dir      <= c_DIR_LEFT;
            r_led      <= c_LED_INIT;
`ifdef CHASER_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
`ifdef CHASER_ABORT_EN
            aborted <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_mode     <= cmd_mode;
                        r_steps    <= cmd_steps;
                        r_step_cnt <= '0;
                        r_tick     <= '0;
                        r_dir      <= c_DIR_LEFT;
                        // Shift modes need a single lit LED to chase.
                        if ((cmd_mode != c_MODE_BLINK) && !w_onehot) begin
                            r_led <= c_LED_INIT;
                        end
                        r_state <= (cmd_steps == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
`ifdef CHASER_ABORT_EN
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                        aborted <= 1'b1;
                    end else if (!pause) begin
`else
                    if (!pause) begin
`endif
                        if (w_tick_wrap) begin
                            r_tick     <= '0;
                            r_led      <= w_led_step;
                            r_dir      <= w_dir_step;
                            r_step_cnt <= r_step_cnt + c_STEP_ONE;
                            if (w_last_step) begin
                                r_state <= c_ST_DONE;
                            end
                        end else begin
                            r_tick <= r_tick + c_TICK_ONE;
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
    assign done      = (r_state == c_ST_DONE);
    assign led_out   = r_led;
    assign cur_mode  = r_mode;

endmodule
`default_nettype wire
